// File: rtl/css_mcu0_el2_dccm_init_ctrl.sv
// css_mcu0_el2_dccm_init_ctrl: zero-initializes every DCCM bank while giving the core per-bank priority
// Ports:
//   clk, rst_l                     core clock, asynchronous active-low reset
//   init_start                     one-cycle request to zero all banks (ignored unless idle)
//   init_busy, init_done           init in progress, one-cycle completion pulse
//   core_clken..core_wr_ecc        per-bank core request
//   mem_clken..mem_wr_ecc          arbitrated per-bank request to the banks
//   mem_dout/mem_ecc               bank read data, forwarded to core_dout/core_ecc
// Config: define CSS_MCU0_DCCM_INIT_ON_RESET_EN to start initialization automatically on reset exit.
module css_mcu0_el2_dccm_init_ctrl #(
   parameter int                NUM_BANKS = 4,
   parameter int                IDX_W     = 10,
   parameter int                DATA_W    = 32,
   parameter int                ECC_W     = 7,
   parameter logic [ECC_W-1:0]  INIT_ECC  = '0
) (
   input  logic                                 clk,
   input  logic                                 rst_l,
   input  logic                                 init_start,
   output logic                                 init_busy,
   output logic                                 init_done,
   input  logic [NUM_BANKS-1:0]                 core_clken,
   input  logic [NUM_BANKS-1:0]                 core_wren,
   input  logic [NUM_BANKS-1:0][IDX_W-1:0]      core_addr,
   input  logic [NUM_BANKS-1:0][DATA_W-1:0]     core_wr_data,
   input  logic [NUM_BANKS-1:0][ECC_W-1:0]      core_wr_ecc,
   output logic [NUM_BANKS-1:0]                 mem_clken,
   output logic [NUM_BANKS-1:0]                 mem_wren,
   output logic [NUM_BANKS-1:0][IDX_W-1:0]      mem_addr,
   output logic [NUM_BANKS-1:0][DATA_W-1:0]     mem_wr_data,
   output logic [NUM_BANKS-1:0][ECC_W-1:0]      mem_wr_ecc,
   input  logic [NUM_BANKS-1:0][DATA_W-1:0]     mem_dout,
   input  logic [NUM_BANKS-1:0][ECC_W-1:0]      mem_ecc,
   output logic [NUM_BANKS-1:0][DATA_W-1:0]     core_dout,
   output logic [NUM_BANKS-1:0][ECC_W-1:0]      core_ecc
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [IDX_W-1:0] LAST = '1;
   state_t                          state, state_nxt;
   logic [NUM_BANKS-1:0][IDX_W-1:0] cnt;
   logic [NUM_BANKS-1:0]            bank_done, done_nxt, init_wr;
   logic                            start;
`ifdef CSS_MCU0_DCCM_INIT_ON_RESET_EN
   // boot is high only in the first cycle after reset release and acts as an implicit init_start
   logic boot;
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) boot <= 1'b1;
      else        boot <= 1'b0;
   assign start = init_start | boot;
`else
   assign start = init_start;
`endif
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      // init writes only fill cycles the core leaves idle on this bank
      assign init_wr[b]     = (state == RUN) & ~core_clken[b] & ~bank_done[b];
      assign done_nxt[b]    = bank_done[b] | (init_wr[b] & (cnt[b] == LAST));
      assign mem_clken[b]   = init_wr[b] | core_clken[b];
      assign mem_wren[b]    = init_wr[b] | core_wren[b];
      assign mem_addr[b]    = init_wr[b] ? cnt[b] : core_addr[b];
      assign mem_wr_data[b] = init_wr[b] ? '0 : core_wr_data[b];
      assign mem_wr_ecc[b]  = init_wr[b] ? INIT_ECC : core_wr_ecc[b];
   end
   assign core_dout = mem_dout;
   assign core_ecc  = mem_ecc;
   assign init_busy = (state == RUN);
   assign init_done = (state == DONE);
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (start ? RUN : IDLE) :
                  (state == RUN)  ? (&done_nxt ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) state <= IDLE;
      else        state <= state_nxt;
   // counters are held cleared outside RUN, so entering RUN always starts from index 0
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) begin
         cnt       <= '0;
         bank_done <= '0;
      end else if (state != RUN) begin
         cnt       <= '0;
         bank_done <= '0;
      end else begin
         for (int i = 0; i < NUM_BANKS; i++)
            if (init_wr[i]) begin
               cnt[i]       <= (cnt[i] == LAST) ? cnt[i] : cnt[i] + IDX_W'(1);
               bank_done[i] <= done_nxt[i];
            end
      end
endmodule

// File: tb/tb_css_mcu0_el2_dccm_init_ctrl.sv
// tb_css_mcu0_el2_dccm_init_ctrl: directed bench for the DCCM init controller (4 banks x 16 words)
module tb_css_mcu0_el2_dccm_init_ctrl;
   logic              clk = 1'b0;
   logic              rst_l = 1'b0;
   logic              init_start = 1'b0;
   logic              init_busy, init_done;
   logic [3:0]        core_clken = '0, core_wren = '0;
   logic [3:0][3:0]   core_addr = '0;
   logic [3:0][31:0]  core_wr_data = '0;
   logic [3:0][6:0]   core_wr_ecc = '0;
   logic [3:0]        mem_clken, mem_wren;
   logic [3:0][3:0]   mem_addr;
   logic [3:0][31:0]  mem_wr_data;
   logic [3:0][6:0]   mem_wr_ecc;
   logic [3:0][31:0]  mem_dout = '0;
   logic [3:0][6:0]   mem_ecc = '0;
   logic [3:0][31:0]  core_dout;
   logic [3:0][6:0]   core_ecc;
   int n_tests = 0, n_fail = 0;

   css_mcu0_el2_dccm_init_ctrl #(.NUM_BANKS(4), .IDX_W(4), .DATA_W(32), .ECC_W(7), .INIT_ECC(7'h00)) dut (
      .clk(clk), .rst_l(rst_l), .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
      .core_clken(core_clken), .core_wren(core_wren), .core_addr(core_addr),
      .core_wr_data(core_wr_data), .core_wr_ecc(core_wr_ecc),
      .mem_clken(mem_clken), .mem_wren(mem_wren), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_wr_ecc(mem_wr_ecc),
      .mem_dout(mem_dout), .mem_ecc(mem_ecc), .core_dout(core_dout), .core_ecc(core_ecc));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] clken, wren; logic [15:0] addr; logic [127:0] wdata; logic [27:0] wecc;
      logic [127:0] dout; logic [27:0] decc;
      logic [3:0] e_clken, e_wren; logic [15:0] e_addr; logic [127:0] e_wdata; logic [27:0] e_wecc;
      logic [127:0] e_dout; logic [27:0] e_decc;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic core_idle;
      core_clken = '0; core_wren = '0; core_addr = '0; core_wr_data = '0; core_wr_ecc = '0;
   endtask

   // expects the init sequence to begin in the current cycle (first write to index 0)
   task automatic expect_full(input string nm);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k <= 16)
            chk($sformatf("%s k=%0d", nm, k),
                {init_busy, init_done, mem_clken, mem_wren, mem_addr, mem_wr_data, mem_wr_ecc},
                {2'b10, 4'hF, 4'hF, {4{4'(k - 1)}}, 128'h0, 28'h0});
         else
            chk($sformatf("%s k=%0d", nm, k), {init_busy, init_done, mem_clken}, {1'b0, k == 17, 4'h0});
         next_cycle();
      end
   endtask

   task automatic run_full(input string nm);
      init_start = 1'b1;
      next_cycle();
      init_start = 1'b0;
      expect_full(nm);
   endtask

   task automatic expect_idle(input string nm, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         chk($sformatf("%s k=%0d", nm, k), {init_busy, init_done, mem_clken}, 6'h0);
         next_cycle();
      end
   endtask

   initial begin
      vecs[0] = '{4'h0, 4'h0, 16'h0, 128'h0, 28'h0, 128'h0, 28'h0,
                  4'h0, 4'h0, 16'h0, 128'h0, 28'h0, 128'h0, 28'h0};
      vecs[1] = '{4'h0, 4'h0, 16'h0, 128'h0, 28'h0, {32'h0, 32'h12345678, 64'h0}, {7'h0, 7'h3C, 14'h0},
                  4'h0, 4'h0, 16'h0, 128'h0, 28'h0, {32'h0, 32'h12345678, 64'h0}, {7'h0, 7'h3C, 14'h0}};
      vecs[2] = '{4'hF, 4'h5, 16'hFEDC, {4{32'hDEADBEEF}}, {4{7'h55}}, 128'h0, 28'h0,
                  4'hF, 4'h5, 16'hFEDC, {4{32'hDEADBEEF}}, {4{7'h55}}, 128'h0, 28'h0};
      vecs[3] = '{4'h9, 4'h8, 16'hF00F, {32'h1, 32'h2, 32'h3, 32'h4}, {7'h7F, 7'h1, 7'h2, 7'h3},
                  {4{32'hCAFEF00D}}, {4{7'h2A}},
                  4'h9, 4'h8, 16'hF00F, {32'h1, 32'h2, 32'h3, 32'h4}, {7'h7F, 7'h1, 7'h2, 7'h3},
                  {4{32'hCAFEF00D}}, {4{7'h2A}}};
      vecs[4] = '{4'h2, 4'h0, 16'h00A0, {64'h0, 32'hFFFFFFFF, 32'h0}, 28'hFFFFFFF, {128{1'b1}}, 28'hFFFFFFF,
                  4'h2, 4'h0, 16'h00A0, {64'h0, 32'hFFFFFFFF, 32'h0}, 28'hFFFFFFF, {128{1'b1}}, 28'hFFFFFFF};

      // reset state, observed while rst_l is still low
      #2;
      chk("reset_busy_done", {init_busy, init_done}, 2'b00);
      next_cycle();
      rst_l = 1'b1;
`ifdef CSS_MCU0_DCCM_INIT_ON_RESET_EN
      next_cycle();
      expect_full("boot_init");
`else
      expect_idle("post_reset_idle", 4);
`endif

      // idle passthrough vectors
      for (int i = 0; i < 5; i++) begin
         core_clken = vecs[i].clken; core_wren = vecs[i].wren; core_addr = vecs[i].addr;
         core_wr_data = vecs[i].wdata; core_wr_ecc = vecs[i].wecc;
         mem_dout = vecs[i].dout; mem_ecc = vecs[i].decc;
         #1;
         chk($sformatf("idle_vec%0d", i),
             {mem_clken, mem_wren, mem_addr, mem_wr_data, mem_wr_ecc, core_dout, core_ecc, init_busy},
             {vecs[i].e_clken, vecs[i].e_wren, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_wecc,
              vecs[i].e_dout, vecs[i].e_decc, 1'b0});
         next_cycle();
      end
      core_idle();
      mem_dout = '0; mem_ecc = '0;

      // plain init, no core traffic
      run_full("full_init");

      // core owns bank 0 for five cycles; bank 0 finishes five cycles later
      init_start = 1'b1;
      next_cycle();
      init_start = 1'b0;
      mem_dout = {32'h0, 32'h0, 32'h0, 32'h0BADF00D};
      for (int k = 1; k <= 22; k++) begin
         logic [3:0] e_clken, e_wren;
         logic [3:0][3:0] e_addr;
         logic [3:0][31:0] e_data;
         logic [3:0][6:0] e_ecc;
         if (k <= 5) begin
            core_clken = 4'b0001; core_wren = 4'b0001; core_addr[0] = 4'd3;
            core_wr_data[0] = 32'hA5A5A5A5; core_wr_ecc[0] = 7'h11;
         end else core_idle();
         e_clken = '0; e_wren = '0; e_addr = '0; e_data = '0; e_ecc = '0;
         if (k <= 5) begin
            e_clken[0] = 1'b1; e_wren[0] = 1'b1; e_addr[0] = 4'd3; e_data[0] = 32'hA5A5A5A5; e_ecc[0] = 7'h11;
         end else if (k <= 21) begin
            e_clken[0] = 1'b1; e_wren[0] = 1'b1; e_addr[0] = 4'(k - 6);
         end
         for (int b = 1; b < 4; b++)
            if (k <= 16) begin
               e_clken[b] = 1'b1; e_wren[b] = 1'b1; e_addr[b] = 4'(k - 1);
            end
         @(negedge clk);
         chk($sformatf("core_prio k=%0d", k),
             {init_busy, init_done, mem_clken, mem_wren, mem_addr, mem_wr_data, mem_wr_ecc, core_dout[0]},
             {k <= 21, k == 22, e_clken, e_wren, e_addr, e_data, e_ecc, 32'h0BADF00D});
         next_cycle();
      end
      core_idle();
      mem_dout = '0;
      expect_idle("after_core_prio", 2);

      // init_start re-pulsed mid-run has no effect
      init_start = 1'b1;
      next_cycle();
      init_start = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         init_start = (k == 8);
         @(negedge clk);
         if (k <= 16)
            chk($sformatf("restart_ignored k=%0d", k), {init_busy, init_done, mem_addr}, {2'b10, {4{4'(k - 1)}}});
         else
            chk($sformatf("restart_ignored k=%0d", k), {init_busy, init_done, mem_clken}, {1'b0, k == 17, 4'h0});
         next_cycle();
      end
      init_start = 1'b0;

      // reset during RUN abandons the sequence
      init_start = 1'b1;
      next_cycle();
      init_start = 1'b0;
      for (int k = 1; k <= 5; k++) next_cycle();
      rst_l = 1'b0;
      core_clken = 4'b1010; core_wren = 4'b1000; core_addr = 16'h1234;
      core_wr_data = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}; core_wr_ecc = {7'h1, 7'h2, 7'h3, 7'h4};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("reset_mirror k=%0d", k),
             {init_busy, init_done, mem_clken, mem_wren, mem_addr, mem_wr_data, mem_wr_ecc},
             {2'b00, 4'b1010, 4'b1000, 16'h1234,
              {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, {7'h1, 7'h2, 7'h3, 7'h4}});
         next_cycle();
      end
      core_idle();
      rst_l = 1'b1;
`ifdef CSS_MCU0_DCCM_INIT_ON_RESET_EN
      next_cycle();
      expect_full("boot_after_abort");
`else
      expect_idle("abort_no_done", 20);
`endif
      run_full("full_after_abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/css_mcu0_el2_dccm_init_ctrl.md
CSS_MCU0_EL2_DCCM_INIT_CTRL -- requirements
Module: css_mcu0_el2_dccm_init_ctrl

Interface
REQ-001 Parameter NUM_BANKS, default 4, number of DCCM banks.
REQ-002 Parameter IDX_W, default 10, per-bank word-index width (bank depth 2**IDX_W).
REQ-003 Parameter DATA_W, default 32, bank data width.
REQ-004 Parameter ECC_W, default 7, bank ECC width.
REQ-005 Parameter INIT_ECC, default all-zero (ECC_W bits), check bits written alongside zero data.
REQ-006 clk  in  1  core clock; one clock domain.
REQ-007 rst_l  in  1  reset; asynchronous, active-low.
REQ-008 init_start  in  1  single-cycle request to zero-initialize all banks.
REQ-009 init_busy  out  1  high while initialization runs.
REQ-010 init_done  out  1  single-cycle pulse when initialization completes.
REQ-011 core_clken  in  NUM_BANKS  per-bank access enable from the core.
REQ-012 core_wren  in  NUM_BANKS  per-bank write enable from the core.
REQ-013 core_addr  in  NUM_BANKS x IDX_W  per-bank word index from the core.
REQ-014 core_wr_data / core_wr_ecc  in  NUM_BANKS x DATA_W / ECC_W  core write data and check bits.
REQ-015 mem_clken, mem_wren, mem_addr, mem_wr_data, mem_wr_ecc  out  same widths  arbitrated bank-side request.
REQ-016 mem_dout / mem_ecc  in, core_dout / core_ecc  out  NUM_BANKS x DATA_W / ECC_W  read-data passthrough.

Function
REQ-017 FSM states: IDLE, RUN, DONE; IDLE -> RUN on init_start; RUN -> DONE when every bank is complete; DONE -> IDLE unconditionally after one cycle.
REQ-018 init_start outside IDLE is ignored; it does not restart or extend the sequence.
REQ-019 Entering RUN clears every per-bank index counter cnt[b] to 0 and every bank_done[b] flag.
REQ-020 In IDLE and DONE, all mem_* outputs are combinational copies of the matching core_* inputs.
REQ-021 In RUN, core has strict priority per bank: when core_clken[b]=1, bank b carries the core request unchanged and cnt[b] holds.
REQ-022 In RUN, when core_clken[b]=0 and bank_done[b]=0, bank b is driven as mem_clken=1, mem_wren=1, mem_addr=cnt[b], mem_wr_data=0, mem_wr_ecc=INIT_ECC, and cnt[b] increments at the clock edge.
REQ-023 An init write to index 2**IDX_W-1 sets bank_done[b]; cnt[b] does not wrap; a done bank passes core traffic only.
REQ-024 RUN -> DONE occurs at the clock edge where the last outstanding bank_done would become set (registered-next AND).
REQ-025 init_busy = (state==RUN); init_done = (state==DONE), exactly one cycle.
REQ-026 core_dout/core_ecc = mem_dout/mem_ecc in all states (zero latency); core reads during RUN are legal and return memory contents.
REQ-027 Banks progress independently; minimum init latency 2**IDX_W cycles of RUN with no core traffic.

Reset
REQ-028 rst_l low asynchronously forces state IDLE, all cnt[b]=0, all bank_done[b]=0, init_busy=0, init_done=0.
REQ-029 Reset during RUN abandons initialization; no init writes are issued while rst_l is low; partial contents are not recovered.

Configuration
REQ-030 Macro CSS_MCU0_DCCM_INIT_ON_RESET_EN: when defined, reset exit enters RUN (counters cleared) in the first cycle after rst_l rises without init_start; when undefined, reset exit enters IDLE and initialization requires init_start.

Verification (NUM_BANKS=4, IDX_W=4, INIT_ECC=7'h00; init_start pulsed in cycle N)
REQ-031 No core traffic -> all four banks write zero to indices 0..15 in cycles N+1..N+16, init_busy high N+1..N+16, init_done=1 only in N+17.
REQ-032 core_clken[0]=1 in cycles N+1..N+5 with core write addr 3 data 0xA5A5A5A5 -> bank 0 carries core write those cycles, bank 0 init ends N+21, init_done=1 in N+22, banks 1-3 finish N+16.
REQ-033 init_start re-pulsed at N+8 -> no counter reset; init_done still in N+17; no second sequence.
REQ-034 rst_l low at N+6 for 2 cycles, macro undefined -> mem_* mirror core_*, init_busy=0, init_done never pulses; new init_start gives full 16-write sequence.
REQ-035 Macro defined, rst_l rises at cycle R -> init writes to index 0 in cycle R+1, init_done in R+17 with no init_start.
REQ-036 Idle, mem_dout[2]=0x12345678, mem_ecc[2]=7'h3C -> core_dout[2]/core_ecc[2] equal them in the same cycle.
